// File: rtl/ram_share_pkg.sv
// rtl/ram_share_pkg.sv - shared types and defaults for the RAM share controller
// Scanner state encoding and default widths used by ram_share_ctrl and ram_scan_timer.
package ram_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_LAST   = 2'd2,
    ST_COMMIT = 2'd3
  } scan_state_t;

  localparam int C_def_addr_bits    = 8;
  localparam int C_def_data_bits    = 8;
  localparam int C_def_shadow_bytes = 4;
  localparam int C_def_refresh_bits = 20;
  localparam int C_max_shadow_bytes = 16;
  localparam int C_idx_bits         = $clog2(C_max_shadow_bytes);

endpackage

// File: rtl/ram_scan_timer.sv
// rtl/ram_scan_timer.sv - refresh counter and SPI-idle edge detector
// Emits a one-cycle pend_set on a falling a_active or when the refresh counter wraps.
module ram_scan_timer
  import ram_share_pkg::*;
#(
  parameter int C_refresh_bits = C_def_refresh_bits
) (
  input  logic clk,
  input  logic reset,
  input  logic a_active,
  output logic pend_set
);

  logic [C_refresh_bits-1:0] refresh_cnt;
  logic                      active_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      active_q    <= 1'b0;
    end else begin
      refresh_cnt <= refresh_cnt + C_refresh_bits'(1);
      active_q    <= a_active;
    end
  end

  // All-ones now means the counter rolls to zero at this edge.
  assign pend_set = (active_q & ~a_active) | (&refresh_cnt);

endmodule

// File: rtl/ram_share_ctrl.sv
// rtl/ram_share_ctrl.sv - SPI/scanner arbiter for the register RAM with shadow snapshot
// Port A owns the RAM while active; idle gaps are used to copy a RAM window into the shadow bank.
module ram_share_ctrl
  import ram_share_pkg::*;
#(
  parameter int C_addr_bits    = C_def_addr_bits,
  parameter int C_data_bits    = C_def_data_bits,
  parameter int C_shadow_base  = 0,
  parameter int C_shadow_bytes = C_def_shadow_bytes,
  parameter int C_refresh_bits = C_def_refresh_bits
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  a_active,
  input  logic                                  a_wr,
  input  logic [C_addr_bits-1:0]                a_addr,
  input  logic [C_data_bits-1:0]                a_wdata,
  output logic [C_data_bits-1:0]                a_rdata,
  output logic                                  ram_wr,
  output logic [C_addr_bits-1:0]                ram_addr,
  output logic [C_data_bits-1:0]                ram_wdata,
  input  logic [C_data_bits-1:0]                ram_rdata,
  output logic [C_shadow_bytes*C_data_bits-1:0] shadow,
  output logic                                  shadow_valid
);

  localparam logic [C_idx_bits-1:0] C_last_idx = C_idx_bits'(C_shadow_bytes - 1);

  scan_state_t                          state, state_nxt;
  logic [C_idx_bits-1:0]                idx, idx_nxt;
  logic [C_idx_bits-1:0]                rd_idx;
  logic                                 rd_issued;
  logic                                 pending;
  logic                                 pend_set;
  logic                                 grant_a;
  logic                                 issue;
  logic                                 leave_idle;
  logic [C_addr_bits-1:0]               scan_addr;
  logic [C_shadow_bytes*C_data_bits-1:0] staging;

  ram_scan_timer #(
    .C_refresh_bits(C_refresh_bits)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .a_active(a_active),
    .pend_set(pend_set)
  );

  assign grant_a   = a_active | a_wr;
  assign scan_addr = C_addr_bits'(C_shadow_base) + C_addr_bits'(idx);
  assign ram_wdata = a_wdata;
  assign a_rdata   = ram_rdata;

  always_comb begin
    ram_wr   = a_wr & grant_a;
    ram_addr = a_addr;
    if (!grant_a && issue) begin
      ram_addr = scan_addr;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    issue      = 1'b0;
    leave_idle = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending && !grant_a) begin
          state_nxt  = ST_SCAN;
          idx_nxt    = '0;
          leave_idle = 1'b1;
        end
      end
      ST_SCAN: begin
        // Port A activity stalls the scan without losing its place.
        if (!grant_a) begin
          issue = 1'b1;
          if (idx == C_last_idx) begin
            state_nxt = ST_LAST;
          end else begin
            idx_nxt = idx + C_idx_bits'(1);
          end
        end
      end
      ST_LAST:   state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      pending      <= 1'b1;
      rd_issued    <= 1'b0;
      rd_idx       <= '0;
      shadow_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      // The snapshot starting now already covers any request raised this cycle.
      pending      <= leave_idle ? 1'b0 : (pending | pend_set);
      rd_issued    <= issue;
      rd_idx       <= idx;
      shadow_valid <= (state == ST_COMMIT);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staging <= '0;
    end else if (rd_issued) begin
      for (int i = 0; i < C_shadow_bytes; i++) begin
        if (rd_idx == C_idx_bits'(i)) begin
          staging[i*C_data_bits +: C_data_bits] <= ram_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= '0;
    end else if (state == ST_COMMIT) begin
      shadow <= staging;
    end
  end

endmodule
